// File: rtl/hamming_pkg.sv
// Shared types for the parity checker datapath.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/parity_skid_buffer.sv
// Two-entry skid buffer: output register plus one skid register, ready/valid on both sides.
module parity_skid_buffer
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  skid_state_e      state_q, state_n;
  logic [WIDTH-1:0] out_q, out_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             s_ready_q, s_ready_n;
  logic             m_valid_q, m_valid_n;
  logic             acc_c, emit_c;

  assign acc_c  = s_valid && s_ready_q;
  assign emit_c = m_valid_q && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      out_q     <= out_n;
      skid_q    <= skid_n;
      s_ready_q <= s_ready_n;
      m_valid_q <= m_valid_n;
    end
  end

  // Handshake flags are precomputed from the next state so they leave flops.
  always_comb begin
    state_n = state_q;
    out_n   = out_q;
    skid_n  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc_c) begin
          state_n = ST_ONE;
          out_n   = s_data;
        end
      end
      ST_ONE: begin
        if (acc_c && emit_c) begin
          out_n = s_data;
        end else if (acc_c) begin
          state_n = ST_FULL;
          skid_n  = s_data;
        end else if (emit_c) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit_c) begin
          state_n = ST_ONE;
          out_n   = skid_q;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    s_ready_n = (state_n != ST_FULL);
    m_valid_n = (state_n != ST_EMPTY);
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = out_q;

endmodule

// File: rtl/even_parity_checker.sv
// Even-parity checker: strips the parity bit, flags errors, counts them with saturation.
module even_parity_checker
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH:0]   s_word,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_err,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky,
  input  logic                  clr
);

  localparam int unsigned BUF_W = DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic             par_err_c;
  logic             acc_err_c;
  logic [BUF_W-1:0] buf_out;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic             sticky_q;

  assign par_err_c = ^s_word;
  assign acc_err_c = s_valid && s_ready && par_err_c;

  parity_skid_buffer #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  ({s_word[DATA_WIDTH:1], par_err_c}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (buf_out)
  );

  assign m_data = buf_out[BUF_W-1:1];
  assign m_err  = buf_out[0];

  // A failed word accepted alongside clr is counted after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (clr) begin
      cnt_q    <= acc_err_c ? CNT_WIDTH'(1) : '0;
      sticky_q <= acc_err_c;
    end else if (acc_err_c) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_WIDTH'(1);
      sticky_q <= 1'b1;
    end
  end

  assign err_count  = cnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_even_parity_checker.sv
// Directed bench for even_parity_checker with a FIFO scoreboard of expected {data, err}.
module tb_even_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_word;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_data;
  logic       m_err;
  logic [7:0] err_count;
  logic       err_sticky;
  logic       clr;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  int         mdl_cnt;
  logic       mdl_sticky;

  always #5 clk = ~clk;

  even_parity_checker #(
    .DATA_WIDTH(3),
    .CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_word     (s_word),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_err      (m_err),
    .err_count  (err_count),
    .err_sticky (err_sticky),
    .clr        (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scores the handshakes visible now, advances one edge, then checks the counter model.
  task automatic step();
    logic       acc, emi, perr;
    logic [3:0] e;
    acc  = s_valid && s_ready;
    emi  = m_valid && m_ready;
    perr = ^s_word;
    if (emi) begin
      if (exp_q.size() == 0) begin
        chk("spurious_emit", 32'(m_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("emit_data", 32'(m_data), 32'(e[3:1]));
        chk("emit_err", 32'(m_err), 32'(e[0]));
      end
    end
    if (acc) exp_q.push_back({s_word[3:1], perr});
    if (clr) begin
      mdl_cnt    = (acc && perr) ? 1 : 0;
      mdl_sticky = acc && perr;
    end else if (acc && perr) begin
      if (mdl_cnt < 255) mdl_cnt++;
      mdl_sticky = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("err_count", 32'(err_count), 32'(mdl_cnt));
    chk("err_sticky", 32'(err_sticky), 32'(mdl_sticky));
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_word = 4'b0; m_ready = 1'b0; clr = 1'b0;
    mdl_cnt = 0; mdl_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("s_ready_after_release", 32'(s_ready), 32'd1);

    // Good word, one-cycle latency
    s_valid = 1'b1; s_word = 4'b1010; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    chk("good_m_valid", 32'(m_valid), 32'd1);
    chk("good_m_data", 32'(m_data), 32'h5);
    chk("good_m_err", 32'(m_err), 32'd0);
    chk("good_err_count", 32'(err_count), 32'd0);
    step();
    chk("good_drained", 32'(m_valid), 32'd0);

    // Bad word
    s_valid = 1'b1; s_word = 4'b1011;
    step();
    s_valid = 1'b0;
    chk("bad_m_err", 32'(m_err), 32'd1);
    chk("bad_err_count", 32'(err_count), 32'd1);
    chk("bad_err_sticky", 32'(err_sticky), 32'd1);
    step();

    // Back-pressure: three words offered, two fit
    m_ready = 1'b0; s_valid = 1'b1;
    s_word = 4'b0011; step();
    s_word = 4'b1100; step();
    chk("full_s_ready", 32'(s_ready), 32'd0);
    s_word = 4'b0110; step();
    chk("full_hold_s_ready", 32'(s_ready), 32'd0);
    chk("stall_m_data", 32'(m_data), 32'h1);
    chk("stall_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    step();
    chk("after_emit_s_ready", 32'(s_ready), 32'd1);
    chk("after_emit_m_data", 32'(m_data), 32'h6);
    step();
    s_valid = 1'b0;
    chk("third_m_data", 32'(m_data), 32'h3);
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // Saturation with 300 failed words, then clear
    s_valid = 1'b1; s_word = 4'b0001;
    for (int i = 0; i < 300; i++) step();
    s_valid = 1'b0;
    step();
    chk("sat_count", 32'(err_count), 32'd255);
    step();
    chk("sat_hold", 32'(err_count), 32'd255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_count", 32'(err_count), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);

    // Clear coinciding with a failed accept
    clr = 1'b1; s_valid = 1'b1; s_word = 4'b0111;
    step();
    clr = 1'b0; s_valid = 1'b0;
    chk("clr_acc_count", 32'(err_count), 32'd1);
    chk("clr_acc_sticky", 32'(err_sticky), 32'd1);
    step();

    // Reset while FULL
    m_ready = 1'b0; s_valid = 1'b1;
    s_word = 4'b1001; step();
    s_word = 4'b0101; step();
    s_valid = 1'b0;
    chk("pre_rst_full", 32'(s_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_m_valid", 32'(m_valid), 32'd0);
    chk("rst_async_s_ready", 32'(s_ready), 32'd0);
    chk("rst_async_count", 32'(err_count), 32'd0);
    exp_q.delete();
    mdl_cnt = 0; mdl_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("no_stale_m_valid", 32'(m_valid), 32'd0);
      step();
    end
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
